// File: rtl/tl_client_arbiter_if.sv
// rtl/tl_client_arbiter_if.sv - two client TL-UL ports and one manager port bundled for tl_client_arbiter
interface tl_client_arbiter_if;
    logic        auto_in_0_a_valid;
    logic        auto_in_0_a_ready;
    logic [2:0]  auto_in_0_a_bits_opcode;
    logic [2:0]  auto_in_0_a_bits_size;
    logic [6:0]  auto_in_0_a_bits_source;
    logic [31:0] auto_in_0_a_bits_address;
    logic [7:0]  auto_in_0_a_bits_mask;
    logic [63:0] auto_in_0_a_bits_data;
    logic        auto_in_0_d_ready;
    logic        auto_in_0_d_valid;
    logic [2:0]  auto_in_0_d_bits_opcode;
    logic [2:0]  auto_in_0_d_bits_size;
    logic [6:0]  auto_in_0_d_bits_source;
    logic        auto_in_0_d_bits_denied;
    logic [63:0] auto_in_0_d_bits_data;
    logic        auto_in_0_d_bits_corrupt;

    logic        auto_in_1_a_valid;
    logic        auto_in_1_a_ready;
    logic [2:0]  auto_in_1_a_bits_opcode;
    logic [2:0]  auto_in_1_a_bits_size;
    logic [6:0]  auto_in_1_a_bits_source;
    logic [31:0] auto_in_1_a_bits_address;
    logic [7:0]  auto_in_1_a_bits_mask;
    logic [63:0] auto_in_1_a_bits_data;
    logic        auto_in_1_d_ready;
    logic        auto_in_1_d_valid;
    logic [2:0]  auto_in_1_d_bits_opcode;
    logic [2:0]  auto_in_1_d_bits_size;
    logic [6:0]  auto_in_1_d_bits_source;
    logic        auto_in_1_d_bits_denied;
    logic [63:0] auto_in_1_d_bits_data;
    logic        auto_in_1_d_bits_corrupt;

    logic        auto_out_a_valid;
    logic        auto_out_a_ready;
    logic [2:0]  auto_out_a_bits_opcode;
    logic [2:0]  auto_out_a_bits_size;
    logic [7:0]  auto_out_a_bits_source;
    logic [31:0] auto_out_a_bits_address;
    logic [7:0]  auto_out_a_bits_mask;
    logic [63:0] auto_out_a_bits_data;
    logic        auto_out_d_valid;
    logic        auto_out_d_ready;
    logic [2:0]  auto_out_d_bits_opcode;
    logic [2:0]  auto_out_d_bits_size;
    logic [7:0]  auto_out_d_bits_source;
    logic        auto_out_d_bits_denied;
    logic [63:0] auto_out_d_bits_data;
    logic        auto_out_d_bits_corrupt;

    // Arbiter view: client A requests, manager ready and manager D responses come in.
    modport slave (
        input  auto_in_0_a_valid, auto_in_0_a_bits_opcode, auto_in_0_a_bits_size,
               auto_in_0_a_bits_source, auto_in_0_a_bits_address, auto_in_0_a_bits_mask,
               auto_in_0_a_bits_data, auto_in_0_d_ready,
               auto_in_1_a_valid, auto_in_1_a_bits_opcode, auto_in_1_a_bits_size,
               auto_in_1_a_bits_source, auto_in_1_a_bits_address, auto_in_1_a_bits_mask,
               auto_in_1_a_bits_data, auto_in_1_d_ready,
               auto_out_a_ready, auto_out_d_valid, auto_out_d_bits_opcode,
               auto_out_d_bits_size, auto_out_d_bits_source, auto_out_d_bits_denied,
               auto_out_d_bits_data, auto_out_d_bits_corrupt,
        output auto_in_0_a_ready, auto_in_0_d_valid, auto_in_0_d_bits_opcode,
               auto_in_0_d_bits_size, auto_in_0_d_bits_source, auto_in_0_d_bits_denied,
               auto_in_0_d_bits_data, auto_in_0_d_bits_corrupt,
               auto_in_1_a_ready, auto_in_1_d_valid, auto_in_1_d_bits_opcode,
               auto_in_1_d_bits_size, auto_in_1_d_bits_source, auto_in_1_d_bits_denied,
               auto_in_1_d_bits_data, auto_in_1_d_bits_corrupt,
               auto_out_a_valid, auto_out_a_bits_opcode, auto_out_a_bits_size,
               auto_out_a_bits_source, auto_out_a_bits_address, auto_out_a_bits_mask,
               auto_out_a_bits_data, auto_out_d_ready
    );

    modport master (
        output auto_in_0_a_valid, auto_in_0_a_bits_opcode, auto_in_0_a_bits_size,
               auto_in_0_a_bits_source, auto_in_0_a_bits_address, auto_in_0_a_bits_mask,
               auto_in_0_a_bits_data, auto_in_0_d_ready,
               auto_in_1_a_valid, auto_in_1_a_bits_opcode, auto_in_1_a_bits_size,
               auto_in_1_a_bits_source, auto_in_1_a_bits_address, auto_in_1_a_bits_mask,
               auto_in_1_a_bits_data, auto_in_1_d_ready,
               auto_out_a_ready, auto_out_d_valid, auto_out_d_bits_opcode,
               auto_out_d_bits_size, auto_out_d_bits_source, auto_out_d_bits_denied,
               auto_out_d_bits_data, auto_out_d_bits_corrupt,
        input  auto_in_0_a_ready, auto_in_0_d_valid, auto_in_0_d_bits_opcode,
               auto_in_0_d_bits_size, auto_in_0_d_bits_source, auto_in_0_d_bits_denied,
               auto_in_0_d_bits_data, auto_in_0_d_bits_corrupt,
               auto_in_1_a_ready, auto_in_1_d_valid, auto_in_1_d_bits_opcode,
               auto_in_1_d_bits_size, auto_in_1_d_bits_source, auto_in_1_d_bits_denied,
               auto_in_1_d_bits_data, auto_in_1_d_bits_corrupt,
               auto_out_a_valid, auto_out_a_bits_opcode, auto_out_a_bits_size,
               auto_out_a_bits_source, auto_out_a_bits_address, auto_out_a_bits_mask,
               auto_out_a_bits_data, auto_out_d_ready
    );
endinterface

// File: rtl/tl_client_arbiter.sv
// rtl/tl_client_arbiter.sv - two-client TL-UL arbiter: round-robin A with burst lock, D routed by source[7]
module tl_client_arbiter (
    input  logic                 clock,
    input  logic                 reset,
    tl_client_arbiter_if.slave   bus
);
    typedef enum logic [1:0] {
        ST_IDLE,
        ST_HOLD,
        ST_BURST
    } state_e;

    state_e      state_q, state_d;
    logic        grant_q, grant_d;
    logic        rr_prio_q, rr_prio_d;
    logic [2:0]  beats_left_q, beats_left_d;

    logic        sel;
    logic        sel_valid;
    logic [2:0]  sel_opcode;
    logic [2:0]  sel_size;
    logic [6:0]  sel_source;
    logic [31:0] sel_address;
    logic [7:0]  sel_mask;
    logic [63:0] sel_data;
    logic        a_fire;
    logic        multi_beat;
    logic [2:0]  first_beats_left;
    logic        d_client;

    // In IDLE the winner is decided live; once locked (HOLD/BURST) the stored grant is muxed.
    always_comb begin
        sel = grant_q;
        if (state_q == ST_IDLE) begin
            if (bus.auto_in_0_a_valid && bus.auto_in_1_a_valid) begin
                sel = rr_prio_q;
            end else begin
                sel = bus.auto_in_1_a_valid;
            end
        end
    end

    always_comb begin
        sel_valid   = sel ? bus.auto_in_1_a_valid        : bus.auto_in_0_a_valid;
        sel_opcode  = sel ? bus.auto_in_1_a_bits_opcode  : bus.auto_in_0_a_bits_opcode;
        sel_size    = sel ? bus.auto_in_1_a_bits_size    : bus.auto_in_0_a_bits_size;
        sel_source  = sel ? bus.auto_in_1_a_bits_source  : bus.auto_in_0_a_bits_source;
        sel_address = sel ? bus.auto_in_1_a_bits_address : bus.auto_in_0_a_bits_address;
        sel_mask    = sel ? bus.auto_in_1_a_bits_mask    : bus.auto_in_0_a_bits_mask;
        sel_data    = sel ? bus.auto_in_1_a_bits_data    : bus.auto_in_0_a_bits_data;
    end

    assign bus.auto_out_a_valid        = sel_valid && !reset;
    assign bus.auto_out_a_bits_opcode  = sel_opcode;
    assign bus.auto_out_a_bits_size    = sel_size;
    assign bus.auto_out_a_bits_source  = {sel, sel_source};
    assign bus.auto_out_a_bits_address = sel_address;
    assign bus.auto_out_a_bits_mask    = sel_mask;
    assign bus.auto_out_a_bits_data    = sel_data;
    assign bus.auto_in_0_a_ready       = !reset && !sel && bus.auto_out_a_ready;
    assign bus.auto_in_1_a_ready       = !reset &&  sel && bus.auto_out_a_ready;

    assign a_fire     = bus.auto_out_a_valid && bus.auto_out_a_ready;
    assign multi_beat = (sel_opcode == 3'd0 || sel_opcode == 3'd1) && (sel_size > 3'd3);

    // Beats remaining after the first; the 3-bit counter tops out at 8-beat (64-byte) transfers.
    always_comb begin
        case (sel_size)
            3'd4:    first_beats_left = 3'd1;
            3'd5:    first_beats_left = 3'd3;
            default: first_beats_left = 3'd7;
        endcase
    end

    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        rr_prio_d    = rr_prio_q;
        beats_left_d = beats_left_q;
        case (state_q)
            ST_IDLE, ST_HOLD: begin
                if (a_fire) begin
                    rr_prio_d = ~sel;
                    if (multi_beat) begin
                        beats_left_d = first_beats_left;
                        grant_d      = sel;
                        state_d      = ST_BURST;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else if (state_q == ST_IDLE && sel_valid) begin
                    grant_d = sel;
                    state_d = ST_HOLD;
                end
            end
            ST_BURST: begin
                if (a_fire) begin
                    beats_left_d = beats_left_q - 3'd1;
                    if (beats_left_q == 3'd1) begin
                        state_d = ST_IDLE;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            grant_q      <= 1'b0;
            rr_prio_q    <= 1'b0;
            beats_left_q <= 3'd0;
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            rr_prio_q    <= rr_prio_d;
            beats_left_q <= beats_left_d;
        end
    end

    // D responses carry no lock: the top source bit alone picks the client.
    assign d_client = bus.auto_out_d_bits_source[7];

    assign bus.auto_in_0_d_valid = bus.auto_out_d_valid && !d_client && !reset;
    assign bus.auto_in_1_d_valid = bus.auto_out_d_valid &&  d_client && !reset;
    assign bus.auto_out_d_ready  = !reset &&
                                   (d_client ? bus.auto_in_1_d_ready : bus.auto_in_0_d_ready);

    assign bus.auto_in_0_d_bits_opcode  = bus.auto_out_d_bits_opcode;
    assign bus.auto_in_0_d_bits_size    = bus.auto_out_d_bits_size;
    assign bus.auto_in_0_d_bits_source  = bus.auto_out_d_bits_source[6:0];
    assign bus.auto_in_0_d_bits_denied  = bus.auto_out_d_bits_denied;
    assign bus.auto_in_0_d_bits_data    = bus.auto_out_d_bits_data;
    assign bus.auto_in_0_d_bits_corrupt = bus.auto_out_d_bits_corrupt;
    assign bus.auto_in_1_d_bits_opcode  = bus.auto_out_d_bits_opcode;
    assign bus.auto_in_1_d_bits_size    = bus.auto_out_d_bits_size;
    assign bus.auto_in_1_d_bits_source  = bus.auto_out_d_bits_source[6:0];
    assign bus.auto_in_1_d_bits_denied  = bus.auto_out_d_bits_denied;
    assign bus.auto_in_1_d_bits_data    = bus.auto_out_d_bits_data;
    assign bus.auto_in_1_d_bits_corrupt = bus.auto_out_d_bits_corrupt;
endmodule
